cordic_rotation_core: RTL
=========================

Name: cordic_rotation_core

Overview:
- Iterative rotation-mode CORDIC engine that computes the sine and cosine of one pre-reduced angle.
- Sits directly between the quadrant handler's two uses:
  - It consumes the reduced angle (|angle| ≤ ~99°, inside CORDIC convergence).
  - It produces the raw sine/cosine that the handler then sign-corrects.
- Carries a tag word (the original, unreduced angle) alongside each operation, so the downstream handler receives a matched angle/result pair.
- One operation in flight at a time; valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 16: width of angle, tag, sine and cosine words.
- ANGLE_FRAC, 11: fractional bits of the angle (radians, signed fixed-point).
- DATA_FRAC, 14: fractional bits of sine/cosine (±1.0 = ±16384).
- ITERATIONS, 14: number of micro-rotations, i = 0..ITERATIONS-1.
- GUARD, 3: extra LSBs carried internally on x, y and z.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset; one clock, synchronous, active-high.
- in_valid, input, 1: angle_in/tag_in are valid.
- in_ready, output, 1: core can accept an operation.
- angle_in, input, DATA_WIDTH: reduced angle, signed, Q(ANGLE_FRAC).
- tag_in, input, DATA_WIDTH: opaque word latched with the angle.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- sine_out, output, DATA_WIDTH: signed, Q(DATA_FRAC).
- cosine_out, output, DATA_WIDTH: signed, Q(DATA_FRAC).
- tag_out, output, DATA_WIDTH: tag_in of this operation.
- range_err, output, 1: |angle_in| exceeded the convergence limit; valid with out_valid.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE, iteration counter = 0.
  - out_valid = 0; sine_out, cosine_out, tag_out and range_err = 0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-operation abandons the operation and produces no output.
- States: IDLE, ROTATE, DONE.
  - in_ready = (state==IDLE) && !rst.
  - out_valid = (state==DONE).
- IDLE, on in_valid && in_ready at an edge:
  - Load x = K·2^(DATA_FRAC+GUARD), where K = 0.6072529350 rounded to nearest.
  - Load y = 0.
  - Load z = angle_in << GUARD.
  - Latch tag_in.
  - Latch range_err = (|angle_in| > ZMAX), where ZMAX = round(1.7432866·2^ANGLE_FRAC) = 3570.
  - Set counter i = 0; go to ROTATE.
- ROTATE, one micro-rotation per cycle:
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y>>>i); y ← y + d·(x>>>i); z ← z − d·atan_lut[i]. All right-shifts are arithmetic.
  - At i == ITERATIONS-1: perform the last iteration, then go to DONE. Otherwise i ← i+1.
- DONE: output registers update on the edge entering DONE:
  - sine_out = sat(round(y >>> GUARD)); cosine_out = sat(round(x >>> GUARD)).
  - Rounding is half-up.
  - Saturation range is [−2^DATA_FRAC, +2^DATA_FRAC].
  - Hold sine_out, cosine_out, tag_out and range_err stable while out_valid && !out_ready.
  - On out_ready: go to IDLE.
- Latency: out_valid rises exactly ITERATIONS cycles after the accepting edge. Throughput is 1 op per ITERATIONS+2 cycles with out_ready tied high.
- Internal widths:
  - x, y: DATA_WIDTH+GUARD+2 bits (the +2 holds the CORDIC gain growth).
  - z: DATA_WIDTH+GUARD bits.
  - No wrap is permitted for any |angle_in| ≤ 2^(DATA_WIDTH-1)−1.
- Out-of-range input: still computed (the result is unspecified but saturated), and range_err = 1.
- Handshake corner cases:
  - in_valid outside IDLE is ignored; the caller holds it.
  - out_ready outside DONE has no effect.
  - in_valid while DONE is not accepted until the cycle after the result handshake.

Decomposition:
- Package cordic_pkg:
  - state enum.
  - K constant.
  - ZMAX.
  - atan_lut table: atan(2^-i)·2^(ANGLE_FRAC+GUARD), rounded to nearest, for i = 0..15.
  - Default widths.
- Sub-module cordic_atan_rom: combinational index → constant, sized by ITERATIONS.

Test Plan:
- Golden values are computed from the quantized angle_in; tolerance is ±6 LSB.
1. Zero angle: angle_in=0, tag_in=16'h1234 → after exactly 14 cycles, out_valid=1, cosine_out≈16384, sine_out≈0, tag_out=16'h1234, range_err=0.
2. π/6: angle_in=1072 → sine_out≈8190, cosine_out≈14190.
3. −π/4: angle_in=−1608 → sine_out≈−11582, cosine_out≈11588.
4. Convergence edge and error flag:
   - angle_in=3539 (~99°) → sine_out≈16182, cosine_out≈−2565, range_err=0.
   - angle_in=3600 → range_err=1, outputs within ±16384.
5. Backpressure:
   - out_ready low for 5 cycles after out_valid → outputs and tag stable, in_ready=0, and a second in_valid is not accepted.
   - Raise out_ready → IDLE next cycle; the second op is accepted and its result is correct.
6. Reset mid-operation: rst for 1 cycle at iteration 7 → out_valid never asserts for that op, in_ready=1 the cycle after rst falls, and a fresh angle_in=1072 gives the scenario-2 result.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the rotation-mode CORDIC core.
// Irrational constants are stored in Q30 and rescaled with round-to-nearest.
package cordic_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ANGLE_FRAC_DEF = 11;
   localparam int DATA_FRAC_DEF  = 14;
   localparam int ITERATIONS_DEF = 14;
   localparam int GUARD_DEF      = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam longint K_Q30    = 64'sd652032874;   // 0.6072529350
   localparam longint ZMAX_Q30 = 64'sd1871839734;  // 1.7432866 rad

   // atan(2^-i) in Q14 (ANGLE_FRAC + GUARD fractional bits)
   localparam int ATAN_LUT [16] = '{
      12868, 7596, 4014, 2037, 1023, 512, 256, 128,
      64,    32,   16,   8,    4,    2,   1,   0
   };

   function automatic longint q30_scale(input longint v, input int frac);
      return (v + (longint'(1) << (29 - frac))) >>> (30 - frac);
   endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent constant lookup for micro-rotation index idx_i.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int ITERATIONS = ITERATIONS_DEF,
   parameter int IDX_W      = 4,
   parameter int Z_WIDTH    = 19
) (
   input  logic [IDX_W-1:0]   idx_i,
   output logic [Z_WIDTH-1:0] atan_o
);

   always_comb begin
      atan_o = '0;
      if (32'(idx_i) < ITERATIONS) begin
         atan_o = Z_WIDTH'(ATAN_LUT[idx_i]);
      end
   end

endmodule

// File: rtl/cordic_rotation_core.sv
// Iterative rotation-mode CORDIC: one micro-rotation per cycle, producing
// sin/cos of a pre-reduced angle together with a pass-through tag.
//
// state     | meaning
// ST_IDLE   | waiting for an angle, in_ready high
// ST_ROTATE | micro-rotation i_q in progress
// ST_DONE   | result held until out_ready
module cordic_rotation_core
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ANGLE_FRAC = ANGLE_FRAC_DEF,
   parameter int DATA_FRAC  = DATA_FRAC_DEF,
   parameter int ITERATIONS = ITERATIONS_DEF,
   parameter int GUARD      = GUARD_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] angle_in,
   input  logic [DATA_WIDTH-1:0] tag_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] sine_out,
   output logic [DATA_WIDTH-1:0] cosine_out,
   output logic [DATA_WIDTH-1:0] tag_out,
   output logic                  range_err
);

   localparam int XW = DATA_WIDTH + GUARD + 2;
   localparam int ZW = DATA_WIDTH + GUARD;
   localparam int IW = $clog2(ITERATIONS);

   localparam logic signed [XW-1:0]     X_INIT = XW'(q30_scale(K_Q30, DATA_FRAC + GUARD));
   localparam logic signed [DATA_WIDTH:0] ZMAX_V = (DATA_WIDTH+1)'(q30_scale(ZMAX_Q30, ANGLE_FRAC));
   localparam logic [IW-1:0]            I_LAST = IW'(ITERATIONS - 1);
   localparam logic signed [XW-1:0]     RND    = XW'(1 << (GUARD - 1));
   localparam logic signed [XW-1:0]     SAT_HI = XW'(1 << DATA_FRAC);
   localparam logic signed [XW-1:0]     SAT_LO = -SAT_HI;

   state_e                 state_q, state_d;
   logic [IW-1:0]          i_q, i_d;
   logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
   logic signed [ZW-1:0]   z_q, z_d;
   logic [DATA_WIDTH-1:0]  tag_q, tag_d;
   logic                   err_q, err_d;
   logic [DATA_WIDTH-1:0]  sin_q, sin_d, cos_q, cos_d, tag_out_q, tag_out_d;
   logic                   err_out_q, err_out_d;

   logic [ZW-1:0]          atan_val;
   logic signed [XW-1:0]   x_sh, y_sh, x_rot, y_rot;
   logic signed [ZW-1:0]   z_rot;
   logic signed [DATA_WIDTH:0] angle_ext, angle_abs;

   cordic_atan_rom #(
      .ITERATIONS (ITERATIONS),
      .IDX_W      (IW),
      .Z_WIDTH    (ZW)
   ) u_atan_rom (
      .idx_i  (i_q),
      .atan_o (atan_val)
   );

   function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] r;
      r = (v + RND) >>> GUARD;
      if (r > SAT_HI) begin
         r = SAT_HI;
      end else if (r < SAT_LO) begin
         r = SAT_LO;
      end
      return r[DATA_WIDTH-1:0];
   endfunction

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = (state_q == ST_DONE);

   // one micro-rotation; direction follows the sign of the residual angle
   always_comb begin
      x_sh  = x_q >>> i_q;
      y_sh  = y_q >>> i_q;
      x_rot = z_q[ZW-1] ? (x_q + y_sh) : (x_q - y_sh);
      y_rot = z_q[ZW-1] ? (y_q - x_sh) : (y_q + x_sh);
      z_rot = z_q[ZW-1] ? (z_q + $signed(atan_val)) : (z_q - $signed(atan_val));
      angle_ext = {angle_in[DATA_WIDTH-1], angle_in};
      angle_abs = angle_ext[DATA_WIDTH] ? -angle_ext : angle_ext;
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      tag_d     = tag_q;
      err_d     = err_q;
      sin_d     = sin_q;
      cos_d     = cos_q;
      tag_out_d = tag_out_q;
      err_out_d = err_out_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               x_d     = X_INIT;
               y_d     = '0;
               z_d     = {angle_in, {GUARD{1'b0}}};
               tag_d   = tag_in;
               err_d   = (angle_abs > ZMAX_V);
               i_d     = '0;
               state_d = ST_ROTATE;
            end
         end
         ST_ROTATE: begin
            x_d = x_rot;
            y_d = y_rot;
            z_d = z_rot;
            if (i_q == I_LAST) begin
               i_d       = '0;
               sin_d     = round_sat(y_rot);
               cos_d     = round_sat(x_rot);
               tag_out_d = tag_q;
               err_out_d = err_q;
               state_d   = ST_DONE;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         i_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         tag_q     <= '0;
         err_q     <= 1'b0;
         sin_q     <= '0;
         cos_q     <= '0;
         tag_out_q <= '0;
         err_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         x_q       <= x_d;
         y_q       <= y_d;
         z_q       <= z_d;
         tag_q     <= tag_d;
         err_q     <= err_d;
         sin_q     <= sin_d;
         cos_q     <= cos_d;
         tag_out_q <= tag_out_d;
         err_out_q <= err_out_d;
      end
   end

   assign sine_out   = sin_q;
   assign cosine_out = cos_q;
   assign tag_out    = tag_out_q;
   assign range_err  = err_out_q;

endmodule
